arrow_key_decoder: RTL and testbench

ARROW_KEY_DECODER -- requirements
Module: arrow_key_decoder

---
 rtl/arrow_key_decoder_pkg.sv | 57 +++++
 rtl/arrow_key_decoder_ps2_prefix_parser.sv | 77 +++++++
 rtl/arrow_key_decoder.sv | 90 +++++++++
 tb/tb_arrow_key_decoder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/arrow_key_decoder_pkg.sv
// Shared game definitions: PS/2 scancodes, direction encoding and parser states.
// Also holds small decode helpers used by the parser and the top.
package arrow_key_decoder_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        PS_IDLE    = 2'd0,
        PS_EXT     = 2'd1,
        PS_BRK     = 2'd2,
        PS_EXT_BRK = 2'd3
    } ps2_state_t;

    typedef struct packed {
        logic hit;
        dir_t dir;
    } arrow_t;

    function automatic arrow_t decode_arrow(input logic [7:0] code);
        arrow_t a;
        a.hit = 1'b1;
        a.dir = DIR_UP;
        case (code)
            SC_UP:    a.dir = DIR_UP;
            SC_DOWN:  a.dir = DIR_DOWN;
            SC_LEFT:  a.dir = DIR_LEFT;
            SC_RIGHT: a.dir = DIR_RIGHT;
            default:  a.hit = 1'b0;
        endcase
        return a;
    endfunction

    // Bit order {up,down,left,right}, matching keys_held and the output group.
    function automatic logic [3:0] dir_onehot(input dir_t d);
        logic [3:0] oh;
        case (d)
            DIR_UP:   oh = 4'b1000;
            DIR_DOWN: oh = 4'b0100;
            DIR_LEFT: oh = 4'b0010;
            default:  oh = 4'b0001;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/arrow_key_decoder_ps2_prefix_parser.sv
// E0/F0 prefix parser with a stale-prefix timeout. Emits one-cycle make/break
// pulses for extended arrow codes together with the 2-bit key code.
module ps2_prefix_parser
    import arrow_key_decoder_pkg::*;
#(
    parameter logic [19:0] PREFIX_TIMEOUT = 20'd500000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [7:0] ps2_byte,
    input  logic       ps2_valid,
    output logic       make_pulse,
    output logic       brk_pulse,
    output logic [1:0] key
);

    ps2_state_t  state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    arrow_t      arrow;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        make_pulse = 1'b0;
        brk_pulse  = 1'b0;
        arrow      = decode_arrow(ps2_byte);
        key        = arrow.dir;

        if (ps2_valid) begin
            cnt_d = '0;
            case (state_q)
                PS_IDLE: begin
                    if (ps2_byte == SC_EXT)      state_d = PS_EXT;
                    else if (ps2_byte == SC_BRK) state_d = PS_BRK;
                end
                PS_EXT: begin
                    if (ps2_byte == SC_BRK)      state_d = PS_EXT_BRK;
                    else if (ps2_byte == SC_EXT) state_d = PS_EXT;
                    else begin
                        state_d    = PS_IDLE;
                        make_pulse = arrow.hit;
                    end
                end
                PS_BRK: state_d = PS_IDLE;
                PS_EXT_BRK: begin
                    state_d   = PS_IDLE;
                    brk_pulse = arrow.hit;
                end
                default: state_d = PS_IDLE;
            endcase
        end else if (state_q != PS_IDLE) begin
            // A prefix whose follow-up byte never came is dropped silently.
            if (cnt_q == PREFIX_TIMEOUT - 20'd1) begin
                state_d = PS_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 20'd1;
            end
        end

        if (resetN) begin
            make_pulse = 1'b0;
            brk_pulse  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            state_q <= PS_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/arrow_key_decoder.sv
// Arrow-key decoder: tracks held arrows, remembers the most recent direction and
// publishes it as a frame-stable one-hot group on each startOfFrame.
module arrow_key_decoder
    import arrow_key_decoder_pkg::*;
#(
    parameter logic [19:0] PREFIX_TIMEOUT = 20'd500000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [7:0] ps2_byte,
    input  logic       ps2_valid,
    input  logic       startOfFrame,
    output logic       upArrowPressed,
    output logic       downArrowPressed,
    output logic       leftArrowPressed,
    output logic       rightArrowPressed,
    output logic [3:0] keys_held
);

    logic       make_pulse, brk_pulse;
    logic [1:0] key;
    dir_t       key_dir;
    logic [3:0] key_oh;

    logic [3:0] held_q, held_d;
    dir_t       last_dir_q, last_dir_d;
    logic       last_vld_q, last_vld_d;
    logic [3:0] arrows_q, arrows_d;

    ps2_prefix_parser #(
        .PREFIX_TIMEOUT(PREFIX_TIMEOUT)
    ) u_parser (
        .clk       (clk),
        .resetN    (resetN),
        .ps2_byte  (ps2_byte),
        .ps2_valid (ps2_valid),
        .make_pulse(make_pulse),
        .brk_pulse (brk_pulse),
        .key       (key)
    );

    always_comb begin
        key_dir    = dir_t'(key);
        key_oh     = dir_onehot(key_dir);
        held_d     = held_q;
        last_dir_d = last_dir_q;
        last_vld_d = last_vld_q;
        arrows_d   = arrows_q;

        // Make is applied after break so a coincident pair leaves the key held.
        if (brk_pulse)  held_d = held_d & ~key_oh;
        if (make_pulse) held_d = held_d | key_oh;

        if (make_pulse) begin
            last_dir_d = key_dir;
            last_vld_d = 1'b1;
        end else if (brk_pulse && last_vld_q && key_dir == last_dir_q) begin
            last_vld_d = |held_d;
            if (held_d[3])      last_dir_d = DIR_UP;
            else if (held_d[2]) last_dir_d = DIR_DOWN;
            else if (held_d[1]) last_dir_d = DIR_LEFT;
            else                last_dir_d = DIR_RIGHT;
        end

        // Uses the registered last_dir so a coincident byte lands next frame.
        if (startOfFrame)
            arrows_d = last_vld_q ? dir_onehot(last_dir_q) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            held_q     <= 4'b0000;
            last_dir_q <= DIR_UP;
            last_vld_q <= 1'b0;
            arrows_q   <= 4'b0000;
        end else begin
            held_q     <= held_d;
            last_dir_q <= last_dir_d;
            last_vld_q <= last_vld_d;
            arrows_q   <= arrows_d;
        end
    end

    assign keys_held         = held_q;
    assign upArrowPressed    = arrows_q[3];
    assign downArrowPressed  = arrows_q[2];
    assign leftArrowPressed  = arrows_q[1];
    assign rightArrowPressed = arrows_q[0];

endmodule

// File: tb/tb_arrow_key_decoder.sv
// Directed bench for arrow_key_decoder with a short prefix timeout (16 cycles).
module tb_arrow_key_decoder;

    logic       clk = 1'b0;
    logic       resetN;
    logic [7:0] ps2_byte;
    logic       ps2_valid;
    logic       startOfFrame;
    logic       up, down, left, right;
    logic [3:0] keys_held;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    arrow_key_decoder #(.PREFIX_TIMEOUT(20'd16)) dut (
        .clk              (clk),
        .resetN           (resetN),
        .ps2_byte         (ps2_byte),
        .ps2_valid        (ps2_valid),
        .startOfFrame     (startOfFrame),
        .upArrowPressed   (up),
        .downArrowPressed (down),
        .leftArrowPressed (left),
        .rightArrowPressed(right),
        .keys_held        (keys_held)
    );

    function automatic logic [3:0] arrows();
        return {up, down, left, right};
    endfunction

    task automatic send(input logic [7:0] b);
        ps2_byte  = b;
        ps2_valid = 1'b1;
        @(posedge clk); #1;
        ps2_valid = 1'b0;
        ps2_byte  = 8'h00;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        @(posedge clk); #1;
        startOfFrame = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        total++;
        if (arrows() !== 4'b0000) begin bad++; $display("FAIL reset_arrows got=%b exp=%b", arrows(), 4'b0000); end
        total++;
        if (keys_held !== 4'b0000) begin bad++; $display("FAIL reset_held got=%b exp=%b", keys_held, 4'b0000); end
    endtask

    task automatic test_make_up();
        send(8'hE0); send(8'h75);
        total++;
        if (keys_held !== 4'b1000) begin bad++; $display("FAIL up_held got=%b exp=%b", keys_held, 4'b1000); end
        total++;
        if (arrows() !== 4'b0000) begin bad++; $display("FAIL up_before_frame got=%b exp=%b", arrows(), 4'b0000); end
        frame();
        total++;
        if (arrows() !== 4'b1000) begin bad++; $display("FAIL up_frame got=%b exp=%b", arrows(), 4'b1000); end
        idle(3);
        total++;
        if (arrows() !== 4'b1000) begin bad++; $display("FAIL up_hold got=%b exp=%b", arrows(), 4'b1000); end
        send(8'hE0); send(8'hF0); send(8'h75); frame();
        total++;
        if ({arrows(), keys_held} !== 8'h00) begin bad++; $display("FAIL up_release got=%h exp=%h", {arrows(), keys_held}, 8'h00); end
    endtask

    task automatic test_left_right();
        send(8'hE0); send(8'h6B); send(8'hE0); send(8'h74); frame();
        total++;
        if ({arrows(), keys_held} !== 8'b0001_0011) begin bad++; $display("FAIL lr_right got=%b exp=%b", {arrows(), keys_held}, 8'b0001_0011); end
        send(8'hE0); send(8'hF0); send(8'h74); frame();
        total++;
        if ({arrows(), keys_held} !== 8'b0010_0010) begin bad++; $display("FAIL lr_left got=%b exp=%b", {arrows(), keys_held}, 8'b0010_0010); end
        send(8'hE0); send(8'hF0); send(8'h6B); frame();
        total++;
        if ({arrows(), keys_held} !== 8'h00) begin bad++; $display("FAIL lr_none got=%b exp=%b", {arrows(), keys_held}, 8'h00); end
    endtask

    task automatic test_non_extended();
        send(8'h6B); send(8'hF0); send(8'h6B); frame();
        total++;
        if ({arrows(), keys_held} !== 8'h00) begin bad++; $display("FAIL nonext got=%b exp=%b", {arrows(), keys_held}, 8'h00); end
        send(8'hE0); send(8'h75);
        total++;
        if (keys_held !== 4'b1000) begin bad++; $display("FAIL nonext_idle got=%b exp=%b", keys_held, 4'b1000); end
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'hE0); send(8'h72);
        total++;
        if (keys_held !== 4'b0100) begin bad++; $display("FAIL ext_repeat got=%b exp=%b", keys_held, 4'b0100); end
        send(8'hE0); send(8'hF0); send(8'h72);
    endtask

    task automatic test_timeout();
        send(8'hE0); idle(16); send(8'h74);
        total++;
        if (keys_held !== 4'b0000) begin bad++; $display("FAIL timeout_expired got=%b exp=%b", keys_held, 4'b0000); end
        send(8'hE0); idle(14); send(8'h74);
        total++;
        if (keys_held !== 4'b0001) begin bad++; $display("FAIL timeout_not_yet got=%b exp=%b", keys_held, 4'b0001); end
        send(8'hE0); send(8'hF0); idle(16); send(8'h74);
        total++;
        if (keys_held !== 4'b0001) begin bad++; $display("FAIL timeout_brk got=%b exp=%b", keys_held, 4'b0001); end
        send(8'hE0); send(8'hF0); send(8'h74);
        total++;
        if (keys_held !== 4'b0000) begin bad++; $display("FAIL timeout_release got=%b exp=%b", keys_held, 4'b0000); end
    endtask

    task automatic test_reset_mid();
        send(8'hE0); send(8'h72); frame();
        total++;
        if ({arrows(), keys_held} !== 8'b0100_0100) begin bad++; $display("FAIL rst_pre got=%b exp=%b", {arrows(), keys_held}, 8'b0100_0100); end
        resetN = 1'b1; idle(1); resetN = 1'b0;
        total++;
        if ({arrows(), keys_held} !== 8'h00) begin bad++; $display("FAIL rst_clear got=%b exp=%b", {arrows(), keys_held}, 8'h00); end
        frame();
        total++;
        if (arrows() !== 4'b0000) begin bad++; $display("FAIL rst_frame got=%b exp=%b", arrows(), 4'b0000); end
        send(8'h72);
        total++;
        if (keys_held !== 4'b0000) begin bad++; $display("FAIL rst_lone72 got=%b exp=%b", keys_held, 4'b0000); end
        send(8'hE0); resetN = 1'b1; idle(1); resetN = 1'b0; send(8'h75);
        total++;
        if (keys_held !== 4'b0000) begin bad++; $display("FAIL rst_partial got=%b exp=%b", keys_held, 4'b0000); end
        resetN = 1'b1; ps2_byte = 8'hE0; ps2_valid = 1'b1; idle(1);
        resetN = 1'b0; ps2_valid = 1'b0; send(8'h75);
        total++;
        if (keys_held !== 4'b0000) begin bad++; $display("FAIL rst_valid_ignored got=%b exp=%b", keys_held, 4'b0000); end
    endtask

    task automatic test_priority();
        send(8'hE0); send(8'h75); send(8'hE0); send(8'h72); frame();
        total++;
        if ({arrows(), keys_held} !== 8'b0100_1100) begin bad++; $display("FAIL prio_down got=%b exp=%b", {arrows(), keys_held}, 8'b0100_1100); end
        send(8'hE0); send(8'hF0); send(8'h72); frame();
        total++;
        if ({arrows(), keys_held} !== 8'b1000_1000) begin bad++; $display("FAIL prio_fallback got=%b exp=%b", {arrows(), keys_held}, 8'b1000_1000); end
        send(8'hE0); send(8'hF0); send(8'h75); frame();
        total++;
        if ({arrows(), keys_held} !== 8'h00) begin bad++; $display("FAIL prio_none got=%b exp=%b", {arrows(), keys_held}, 8'h00); end
    endtask

    task automatic test_typematic();
        send(8'hE0); send(8'h6B); send(8'hE0); send(8'h74); send(8'hE0); send(8'h6B); frame();
        total++;
        if ({arrows(), keys_held} !== 8'b0010_0011) begin bad++; $display("FAIL typematic got=%b exp=%b", {arrows(), keys_held}, 8'b0010_0011); end
        send(8'hE0); send(8'hF0); send(8'h6B); frame();
        total++;
        if ({arrows(), keys_held} !== 8'b0001_0001) begin bad++; $display("FAIL typematic_fb got=%b exp=%b", {arrows(), keys_held}, 8'b0001_0001); end
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h74); frame();
        total++;
        if ({arrows(), keys_held} !== 8'b1000_1000) begin bad++; $display("FAIL other_release got=%b exp=%b", {arrows(), keys_held}, 8'b1000_1000); end
    endtask

    task automatic test_back_to_back();
        send(8'hE0);
        ps2_byte = 8'h72; ps2_valid = 1'b1; startOfFrame = 1'b1;
        idle(1);
        ps2_valid = 1'b0; startOfFrame = 1'b0;
        total++;
        if ({arrows(), keys_held} !== 8'b1000_1100) begin bad++; $display("FAIL coincident got=%b exp=%b", {arrows(), keys_held}, 8'b1000_1100); end
        frame();
        total++;
        if (arrows() !== 4'b0100) begin bad++; $display("FAIL coincident_next got=%b exp=%b", arrows(), 4'b0100); end
        send(8'hE0); send(8'hF0); send(8'h75); frame();
        total++;
        if ({arrows(), keys_held} !== 8'b0100_0100) begin bad++; $display("FAIL b2b_keep got=%b exp=%b", {arrows(), keys_held}, 8'b0100_0100); end
        send(8'hE0); send(8'hF0); send(8'h72); frame();
        total++;
        if ({arrows(), keys_held} !== 8'h00) begin bad++; $display("FAIL b2b_clear got=%b exp=%b", {arrows(), keys_held}, 8'h00); end
    endtask

    initial begin
        resetN = 1'b1; ps2_byte = 8'h00; ps2_valid = 1'b0; startOfFrame = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetN = 1'b0;
        test_reset();
        test_make_up();
        test_left_right();
        test_non_extended();
        test_timeout();
        test_reset_mid();
        test_priority();
        test_typematic();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
